// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Word-wide data-memory bus between the load/store unit (master) and a
// synchronous-read data memory (slave).
//   mem_we    : write enable, one cycle per store
//   mem_addr  : word-aligned byte address
//   mem_wd    : write data, 0 when not writing
//   mem_rdata : read data, valid the cycle after the address is presented
interface load_store_unit_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rdata;

  modport master (output mem_we, mem_addr, mem_wd, input mem_rdata);
  modport slave  (input mem_we, mem_addr, mem_wd, output mem_rdata);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Executes one RV32I load or store at a time against a word-wide memory with
// registered reads. Sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req, is_store, funct3 : request strobe, direction, RV32I width code
//   addr, store_data      : byte address, store source
//   load_data             : registered, extended load result
//   done, err, busy       : completion pulse, error pulse, not-idle flag
//   mem                   : memory bus (master side)
//
// state  | meaning
// IDLE   | waiting for req; done/err of the previous access visible here
// RD     | load: word address presented for read
// CAP    | load: read data valid, extracted into load_data at exit
// RMW_RD | SB/SH: word address presented for read
// MERGE  | SB/SH: write back read word with the target lane replaced
// WR     | SW: full-word write
// ERR    | rejected request, done/err high, no memory access
module load_store_unit #(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        done,
  output logic        err,
  output logic        busy,
  load_store_unit_if.master mem
);

  typedef enum logic [2:0] {IDLE, RD, CAP, RMW_RD, MERGE, WR, ERR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] load_data_q, load_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        mem_we_o;
  logic [31:0] mem_wd_o;
  logic        bad_req;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic [31:0] merged;

  always_comb begin
    bad_req = 1'b0;
    if (is_store && funct3 >= 3'd3) bad_req = 1'b1;
    if (!is_store && (funct3 == 3'd3 || funct3 >= 3'd6)) bad_req = 1'b1;
    if ((funct3 == 3'd1 || funct3 == 3'd5) && addr[0]) bad_req = 1'b1;
    if (funct3 == 3'd2 && addr[1:0] != 2'b00) bad_req = 1'b1;
    if (addr >= ADDR_LIMIT) bad_req = 1'b1;
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    rd_byte = mem.mem_rdata[{addr_lo_q, 3'b000} +: 8];
    rd_half = addr_lo_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'd0:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    rd_ext = {24'd0, rd_byte};
      3'd1:    rd_ext = {{16{rd_half[15]}}, rd_half};
      3'd5:    rd_ext = {16'd0, rd_half};
      default: rd_ext = mem.mem_rdata;
    endcase
    merged = mem.mem_rdata;
    if (funct3_q == 3'd0) merged[{addr_lo_q, 3'b000} +: 8] = store_data_q[7:0];
    else                  merged[{addr_lo_q[1], 4'b0000} +: 16] = store_data_q[15:0];
  end

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    store_data_d = store_data_q;
    mem_addr_d   = mem_addr_q;
    load_data_d  = load_data_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    mem_we_o     = 1'b0;
    mem_wd_o     = 32'd0;
    case (state_q)
      IDLE: begin
        if (req) begin
          funct3_d     = funct3;
          addr_lo_d    = addr[1:0];
          store_data_d = store_data;
          if (bad_req) begin
            state_d = ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            // Address stays registered so RMW_RD and MERGE see the same word.
            mem_addr_d = {addr[31:2], 2'b00};
            if (!is_store)            state_d = RD;
            else if (funct3 == 3'd2)  state_d = WR;
            else                      state_d = RMW_RD;
          end
        end
      end
      RD:     state_d = CAP;
      CAP: begin
        load_data_d = rd_ext;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      RMW_RD: state_d = MERGE;
      MERGE: begin
        mem_we_o = 1'b1;
        mem_wd_o = merged;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      WR: begin
        mem_we_o = 1'b1;
        mem_wd_o = store_data_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      store_data_q <= 32'd0;
      mem_addr_q   <= 32'd0;
      load_data_q  <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      store_data_q <= store_data_d;
      mem_addr_q   <= mem_addr_d;
      load_data_q  <= load_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Write strobe decodes straight from state so reset kills it at once.
  assign mem.mem_we   = mem_we_o;
  assign mem.mem_wd   = mem_wd_o;
  assign mem.mem_addr = mem_addr_q;
  assign load_data    = load_data_q;
  assign done         = done_q;
  assign err          = err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk, rst_n, req, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data;
  logic        done, err, busy;

  load_store_unit_if bus();

  load_store_unit #(.ADDR_LIMIT(4096)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .load_data(load_data), .done(done), .err(err), .busy(busy), .mem(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int exp_dones = 0;

  // ---------------- memory environment ----------------
  logic [31:0] mem [1024];
  int          wr_count = 0;
  logic [31:0] last_wa = 0, last_wd = 0;

  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_we ? 32'd0 : mem[bus.mem_addr[11:2]];
    if (bus.mem_we) begin
      mem[bus.mem_addr[11:2]] = bus.mem_wd;
      wr_count <= wr_count + 1;
      last_wa  <= bus.mem_addr;
      last_wd  <= bus.mem_wd;
    end
  end

  int   busy_count = 0, done_count = 0, viol = 0;
  logic prev_we = 0;
  always @(negedge clk) begin
    busy_count <= busy_count + int'(busy);
    done_count <= done_count + int'(done);
    if (!bus.mem_we && bus.mem_wd != 0) viol <= viol + 1;
    if (bus.mem_addr[1:0] != 2'b00) viol <= viol + 1;
    if (bus.mem_we && prev_we) viol <= viol + 1;
    if (done !== err && err) viol <= viol + 1;
    prev_we <= bus.mem_we;
  end

  // ---------------- reference model ----------------
  bit [31:0] ref_mem [1024];
  bit [31:0] ref_ld = 0;

  task automatic model_op(input bit st, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] sd, output bit e, output bit [31:0] ld,
                          output int lat, output int nwr, output bit [31:0] wd);
    bit legal;
    int size, lo, off, idx;
    bit [31:0] w, x, mask;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    e     = !legal || (a % size != 0) || (a >= 4096);
    lat = 0; nwr = 0; wd = 0;
    if (!e) begin
      idx = int'(a / 4);
      lo  = int'(a % 4);
      w   = ref_mem[idx];
      if (!st) begin
        case (f3)
          3'd0, 3'd4: begin
            x = (w >> (8 * lo)) & 32'hFF;
            if (f3 == 3'd0 && x >= 32'h80) x = x | 32'hFFFFFF00;
          end
          3'd1, 3'd5: begin
            x = (w >> (16 * (lo / 2))) & 32'hFFFF;
            if (f3 == 3'd1 && x >= 32'h8000) x = x | 32'hFFFF0000;
          end
          default: x = w;
        endcase
        ref_ld = x;
        lat = 2;
      end else if (f3 == 3'd2) begin
        ref_mem[idx] = sd;
        wd = sd; lat = 1; nwr = 1;
      end else begin
        off  = (f3 == 3'd0) ? lo : (lo / 2) * 2;
        mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
        ref_mem[idx] = (w & ~mask) | ((sd << (8 * off)) & mask);
        wd = ref_mem[idx]; lat = 2; nwr = 1;
      end
    end
    ld = ref_ld;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Called at #1 after an edge with the DUT idle; returns in the done cycle
  // (or the cycle after ERR) so the next call exercises back-to-back issue.
  task automatic run_op(input bit st, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] sd, output bit [31:0] ld, output bit e,
                        output int lat, output int nwr, output bit [31:0] wd,
                        output bit [31:0] wa, output int nb);
    int wr0, b0;
    wr0 = wr_count; b0 = busy_count;
    req = 1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk); #1;
    req = 0;
    lat = -1; e = 0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (done) begin lat = i; e = err; break; end
    end
    if (e) begin @(posedge clk); #1; end
    exp_dones++;
    ld = load_data; nwr = wr_count - wr0; wd = last_wd; wa = last_wa;
    nb = busy_count - b0;
  endtask

  typedef struct {
    bit        st;
    bit [2:0]  f3;
    bit [31:0] a;
    bit [31:0] sd;
    bit        e;
    bit [31:0] ld;
    int        lat;
    int        nwr;
    bit [31:0] wd;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  bit [31:0] g_ld, g_wd, g_wa, m_ld, m_wd;
  bit        g_e, m_e;
  int        g_lat, g_nwr, g_nb, m_lat, m_nwr;

  initial begin
    bit        r_st;
    bit [2:0]  r_f3;
    bit [31:0] r_a, r_sd;
    bit        s_st [4];
    bit [2:0]  s_f3 [4];
    bit [31:0] s_a [4], s_sd [4];
    int        wr0, d0, acc, dn, mem_bad;
    logic      prev_busy;

    vecs[0]  = '{0, 3'd0, 32'h101, 32'h0, 0, 32'h0000007F, 2, 0, 32'h0};
    vecs[1]  = '{0, 3'd0, 32'h102, 32'h0, 0, 32'hFFFFFFFF, 2, 0, 32'h0};
    vecs[2]  = '{0, 3'd4, 32'h103, 32'h0, 0, 32'h00000080, 2, 0, 32'h0};
    vecs[3]  = '{0, 3'd1, 32'h102, 32'h0, 0, 32'hFFFF80FF, 2, 0, 32'h0};
    vecs[4]  = '{0, 3'd5, 32'h100, 32'h0, 0, 32'h00007F01, 2, 0, 32'h0};
    vecs[5]  = '{0, 3'd2, 32'h100, 32'h0, 0, 32'h80FF7F01, 2, 0, 32'h0};
    vecs[6]  = '{1, 3'd1, 32'h202, 32'hDEADBEEF, 0, 32'h80FF7F01, 2, 1, 32'hBEEF3344};
    vecs[7]  = '{0, 3'd2, 32'h200, 32'h0, 0, 32'hBEEF3344, 2, 0, 32'h0};
    vecs[8]  = '{1, 3'd2, 32'h010, 32'hCAFEBABE, 0, 32'hBEEF3344, 1, 1, 32'hCAFEBABE};
    vecs[9]  = '{0, 3'd2, 32'h010, 32'h0, 0, 32'hCAFEBABE, 2, 0, 32'h0};
    vecs[10] = '{0, 3'd2, 32'h102, 32'h0, 1, 32'hCAFEBABE, 0, 0, 32'h0};
    vecs[11] = '{1, 3'd1, 32'h001, 32'h1234, 1, 32'hCAFEBABE, 0, 0, 32'h0};
    vecs[12] = '{0, 3'd0, 32'h1000, 32'h0, 1, 32'hCAFEBABE, 0, 0, 32'h0};
    vecs[13] = '{0, 3'd3, 32'h100, 32'h0, 1, 32'hCAFEBABE, 0, 0, 32'h0};
    vecs[14] = '{1, 3'd4, 32'h100, 32'h55, 1, 32'hCAFEBABE, 0, 0, 32'h0};
    vecs[15] = '{1, 3'd0, 32'h203, 32'h000000A5, 0, 32'hCAFEBABE, 2, 1, 32'hA5EF3344};
    vecs[16] = '{0, 3'd0, 32'h203, 32'h0, 0, 32'hFFFFFFA5, 2, 0, 32'h0};
    vecs[17] = '{0, 3'd2, 32'hFFC, 32'h0, 0, 32'h00000000, 2, 0, 32'h0};
    vecs[18] = '{0, 3'd5, 32'hFFF, 32'h0, 1, 32'h00000000, 0, 0, 32'h0};
    vecs[19] = '{0, 3'd4, 32'hFFF, 32'h0, 0, 32'h00000000, 2, 0, 32'h0};
    vecs[20] = '{0, 3'd6, 32'h100, 32'h0, 1, 32'h00000000, 0, 0, 32'h0};

    for (int i = 0; i < 1024; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    mem[32'h100 >> 2] = 32'h80FF7F01; ref_mem[32'h100 >> 2] = 32'h80FF7F01;
    mem[32'h200 >> 2] = 32'h11223344; ref_mem[32'h200 >> 2] = 32'h11223344;
    mem[32'h300 >> 2] = 32'h12345678; ref_mem[32'h300 >> 2] = 32'h12345678;

    rst_n = 0; req = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
    #22;
    chk("reset_ctl", {28'd0, done, err, busy, bus.mem_we}, 32'd0);
    chk("reset_load_data", load_data, 32'd0);
    chk("reset_mem_bus", bus.mem_addr | bus.mem_wd, 32'd0);
    #5 rst_n = 1;
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < NV; i++) begin
      model_op(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd, m_e, m_ld, m_lat, m_nwr, m_wd);
      run_op(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd, g_ld, g_e, g_lat, g_nwr, g_wd, g_wa, g_nb);
      chk($sformatf("v%0d_err", i), 32'(g_e), 32'(vecs[i].e));
      chk($sformatf("v%0d_load_data", i), g_ld, vecs[i].ld);
      chk($sformatf("v%0d_latency", i), g_lat, vecs[i].lat);
      chk($sformatf("v%0d_writes", i), g_nwr, vecs[i].nwr);
      chk($sformatf("v%0d_busy_cycles", i), g_nb, vecs[i].e ? 1 : vecs[i].lat);
      if (vecs[i].nwr == 1) begin
        chk($sformatf("v%0d_wdata", i), g_wd, vecs[i].wd);
        chk($sformatf("v%0d_waddr", i), g_wa, vecs[i].a & 32'hFFFF_FFFC);
      end
    end

    // SB with reset pulled during MERGE
    req = 1; is_store = 1; funct3 = 3'd0; addr = 32'h302; store_data = 32'h55;
    @(posedge clk); #1;
    req = 0;
    @(posedge clk); #1;
    chk("merge_we", 32'(bus.mem_we), 32'd1);
    chk("merge_addr", bus.mem_addr, 32'h300);
    wr0 = wr_count; d0 = done_count;
    #2 rst_n = 0;
    #1;
    chk("async_rst_ctl", {28'd0, done, err, busy, bus.mem_we}, 32'd0);
    chk("async_rst_load_data", load_data, 32'd0);
    chk("async_rst_bus", bus.mem_addr | bus.mem_wd, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_no_write", wr_count - wr0, 0);
    chk("rst_word_kept", mem[32'h300 >> 2], 32'h12345678);
    chk("rst_no_done", done_count - d0, 0);
    ref_ld = 0;
    model_op(0, 3'd2, 32'h300, 0, m_e, m_ld, m_lat, m_nwr, m_wd);
    run_op(0, 3'd2, 32'h300, 0, g_ld, g_e, g_lat, g_nwr, g_wd, g_wa, g_nb);
    chk("post_rst_lw_data", g_ld, 32'h12345678);
    chk("post_rst_lw_latency", g_lat, 2);

    // req held high across four mixed operations
    s_st[0] = 1; s_f3[0] = 3'd2; s_a[0] = 32'h400; s_sd[0] = 32'h11111111;
    s_st[1] = 0; s_f3[1] = 3'd2; s_a[1] = 32'h400; s_sd[1] = 32'h0;
    s_st[2] = 1; s_f3[2] = 3'd0; s_a[2] = 32'h401; s_sd[2] = 32'hFFFFFFAB;
    s_st[3] = 0; s_f3[3] = 3'd2; s_a[3] = 32'h400; s_sd[3] = 32'h0;
    acc = 0; dn = 0; prev_busy = busy;
    req = 1; is_store = s_st[0]; funct3 = s_f3[0]; addr = s_a[0]; store_data = s_sd[0];
    for (int c = 0; c < 40 && dn < 4; c++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        acc++;
        if (acc < 4) begin
          is_store = s_st[acc]; funct3 = s_f3[acc]; addr = s_a[acc]; store_data = s_sd[acc];
        end else req = 0;
      end
      prev_busy = busy;
      if (done) dn++;
    end
    req = 0;
    exp_dones += 4;
    for (int k = 0; k < 4; k++) model_op(s_st[k], s_f3[k], s_a[k], s_sd[k], m_e, m_ld, m_lat, m_nwr, m_wd);
    chk("hold_req_accepts", acc, 4);
    chk("hold_req_dones", dn, 4);
    chk("hold_req_load_data", load_data, 32'h1111AB11);
    chk("hold_req_mem", mem[32'h400 >> 2], 32'h1111AB11);
    @(posedge clk); #1;

    // randomized operations against the model
    for (int n = 0; n < 80; n++) begin
      r_st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) r_f3 = r_st ? 3'($urandom_range(0, 2))
                                               : 3'(($urandom_range(0, 4) + 3) % 6 + ($urandom_range(0,4) == 0 ? 0 : 0));
      else r_f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       r_a = 32'h1000 + $urandom_range(0, 255);
        1:       r_a = 32'hFFC + $urandom_range(0, 3);
        default: r_a = 32'h500 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
      endcase
      r_sd = $urandom;
      model_op(r_st, r_f3, r_a, r_sd, m_e, m_ld, m_lat, m_nwr, m_wd);
      run_op(r_st, r_f3, r_a, r_sd, g_ld, g_e, g_lat, g_nwr, g_wd, g_wa, g_nb);
      chk($sformatf("r%0d_err", n), 32'(g_e), 32'(m_e));
      chk($sformatf("r%0d_load_data", n), g_ld, m_ld);
      chk($sformatf("r%0d_latency", n), g_lat, m_lat);
      chk($sformatf("r%0d_writes", n), g_nwr, m_nwr);
      if (m_nwr == 1) begin
        chk($sformatf("r%0d_wdata", n), g_wd, m_wd);
        chk($sformatf("r%0d_waddr", n), g_wa, r_a & 32'hFFFF_FFFC);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse_total", done_count, exp_dones);
    chk("bus_protocol_violations", viol, 0);
    mem_bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mem_bad++;
    chk("memory_image_mismatches", mem_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 4096, the byte-address bound of data memory; addresses >= ADDR_LIMIT are errors.
REQ-002 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req  in  1  CPU access request, sampled only in IDLE.
REQ-005 SHALL have ports: is_store  in  1  1 = store, 0 = load.
REQ-006 SHALL have ports: funct3  in  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-007 SHALL have ports: addr  in  32  byte address.
REQ-008 SHALL have ports: store_data  in  32  store source; the low byte or halfword is used for SB/SH.
REQ-009 SHALL have ports: load_data  out  32  registered, extended load result.
REQ-010 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: err  out  1  one-cycle error pulse, coincident with done.
REQ-012 SHALL have ports: busy  out  1  high whenever the state is not IDLE.
REQ-013 SHALL have ports: mem_we  out  1  memory write enable.
REQ-014 SHALL have ports: mem_addr  out  32  memory byte address, always word-aligned with bits [1:0] = 0.
REQ-015 SHALL have ports: mem_wd  out  32  memory write data.
REQ-016 SHALL have ports: mem_rdata  in  32  memory read data.
REQ-017 SHALL treat the memory as follows: a read is registered, and data is valid the cycle after the address is presented with mem_we=0; write cycles return 0.

Function
REQ-018 SHALL accept a request when req=1 in IDLE at edge E0, latching is_store, funct3, addr and store_data; req while busy SHALL be ignored.
REQ-019 SHALL use states IDLE, RD, CAP, RMW_RD, MERGE, WR, and ERR.
REQ-020 SHALL route an error from IDLE to ERR; an error is any of:
- misaligned address: H/HU with addr[0]=1, or W with addr[1:0]!=0;
- illegal funct3: load with 3, 6 or 7, or store with funct3 >= 3;
- addr >= ADDR_LIMIT.
REQ-021 SHALL make ERR last one cycle with done=1 and err=1, no memory access, and load_data unchanged; the next state SHALL be IDLE.
REQ-022 SHALL handle loads as IDLE -> RD -> CAP -> IDLE:
- RD drives mem_addr={addr[31:2],2'b00} with mem_we=0;
- in CAP, mem_rdata is valid, and load_data plus the done pulse are registered at the CAP-exit edge, so done is high during the cycle after E2.
REQ-023 SHALL extract load data by addr[1:0]: B/BU select byte addr[1:0], H/HU select halfword addr[1]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-024 SHALL handle SW as IDLE -> WR -> IDLE: WR drives mem_we=1, the word address and mem_wd=store_data, and done is high during the cycle after E1.
REQ-025 SHALL handle SB/SH as a read-modify-write, IDLE -> RMW_RD -> MERGE -> IDLE:
- RMW_RD drives a read of the word;
- MERGE drives mem_we=1 with mem_wd equal to mem_rdata with the target byte or halfword replaced by the low bits of store_data and all other bytes preserved;
- mem_addr SHALL be identical in RMW_RD and MERGE, and done is high during the cycle after E2.
REQ-026 SHALL assert mem_we only in WR and MERGE, exactly one cycle per store.
REQ-027 SHALL drive mem_wd=0 whenever mem_we=0.
REQ-028 SHALL hold mem_addr at its last value when idle.
REQ-029 SHALL make done and err registered outputs, high for exactly one cycle per accepted request; load_data SHALL hold its value between loads and SHALL not change on stores or errors.
REQ-030 SHALL allow back-to-back requests: a req present in the cycle done is high SHALL be accepted at the next edge, giving no dead cycle beyond IDLE.

Reset
REQ-031 SHALL, when rst_n=0, immediately and asynchronously force state IDLE, mem_we=0, mem_addr=0, mem_wd=0, load_data=0, done=0, err=0 and busy=0.
REQ-032 SHALL, on reset during MERGE or WR, deassert mem_we before the next edge so that no memory write occurs; the in-flight request is discarded, with no done pulse.

Verification
REQ-033 SHALL cover scenario: word 0x100 holds 0x80FF7F01; LB addr 0x101 -> load_data 0x0000007F; LB 0x102 -> 0xFFFFFFFF; LBU 0x103 -> 0x00000080; each done 2 cycles after acceptance.
REQ-034 SHALL cover scenario: word 0x200 holds 0x11223344; SH addr 0x202 with store_data 0xDEADBEEF -> a single write cycle with mem_wd 0xBEEF3344, then LW 0x200 -> 0xBEEF3344.
REQ-035 SHALL cover scenario: SW addr 0x010 with store_data 0xCAFEBABE -> mem_we high one cycle, mem_addr 0x010, done the next cycle, busy high exactly 1 cycle.
REQ-036 SHALL cover scenario: LW addr 0x102, then SH addr 0x001, then LB addr 0x1000 -> each gives done=err=1 the cycle after acceptance, mem_we never asserted, load_data unchanged.
REQ-037 SHALL cover scenario: SB accepted, with rst_n pulled low during MERGE -> mem_we drops immediately, target word unchanged, all outputs 0, and a new LW after reset release completes normally.
REQ-038 SHALL cover scenario: req held high continuously for 4 mixed loads/stores -> each accepted only in IDLE, exactly 4 done pulses, and req while busy ignored.
